// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, programmable framing, divisor-based bit timing
// and break generation. The serial line and status outputs are registered one cycle behind the FSM state.
module uart_tx_fifo #(
    parameter int MAX_DATA_BITS = 9,
    parameter int DIV_WIDTH     = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int LVL_WIDTH     = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [MAX_DATA_BITS-1:0] din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [DIV_WIDTH-1:0]     cfg_div,
    input  logic [3:0]               cfg_data_bits,
    input  logic [2:0]               cfg_parity,
    input  logic                     cfg_stop2,
    input  logic                     tx_break,
    output logic                     tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic [LVL_WIDTH-1:0]     fifo_level
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LVL_WIDTH-1:0] FULL_LVL = LVL_WIDTH'(FIFO_DEPTH);
    localparam logic [3:0] MIN_BITS = 4'd5;
    localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t state, state_nxt;

    logic [MAX_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [LVL_WIDTH-1:0]     level;
    logic                     push, pop, empty;
    logic [MAX_DATA_BITS-1:0] head;

    assign din_ready  = (level != FULL_LVL);
    assign empty      = (level == '0);
    assign push       = din_valid & din_ready;
    assign head       = mem[rd_ptr];
    assign fifo_level = level;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Frame settings derived from the live cfg_* inputs; only captured at a pop.
    logic [3:0]               nbits_in;
    logic [MAX_DATA_BITS-1:0] mask;
    logic                     par_in, has_par_in;

    always_comb begin
        nbits_in   = cfg_data_bits;
        mask       = '0;
        par_in     = 1'b0;
        has_par_in = 1'b1;
        if (cfg_data_bits < MIN_BITS)
            nbits_in = MIN_BITS;
        else if (cfg_data_bits > MAX_BITS)
            nbits_in = MAX_BITS;
        for (int i = 0; i < MAX_DATA_BITS; i++)
            mask[i] = (4'(i) < nbits_in);
        case (cfg_parity)
            3'b001:  par_in = ^(head & mask);
            3'b010:  par_in = ~^(head & mask);
            3'b011:  par_in = 1'b1;
            3'b100:  par_in = 1'b0;
            default: has_par_in = 1'b0;
        endcase
    end

    logic [MAX_DATA_BITS-1:0] sh;
    logic [DIV_WIDTH-1:0]     div_q, cnt;
    logic [3:0]               nbits_q, bit_idx;
    logic                     has_par_q, par_q, stop2_q;
    logic                     bit_end, last_data, last_stop, stop_end;

    always_ff @(posedge clock) begin
        if (pop) begin
            sh        <= head;
            div_q     <= cfg_div;
            nbits_q   <= nbits_in;
            has_par_q <= has_par_in;
            par_q     <= par_in;
            stop2_q   <= cfg_stop2;
        end else if (state == DATA && bit_end) begin
            sh <= sh >> 1;
        end
    end

    assign bit_end   = (cnt == div_q);
    assign last_data = (bit_idx == nbits_q - 4'd1);
    assign last_stop = (bit_idx == {3'b000, stop2_q});
    assign stop_end  = (state == STOP) && bit_end && last_stop;
    // A pop happens from IDLE or back-to-back in the last clock of the stop bits.
    assign pop       = ((state == IDLE) || stop_end) && !tx_break && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            if (state_nxt != state || bit_end || state == IDLE || state == BREAK)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state_nxt != state)
                bit_idx <= '0;
            else if (bit_end)
                bit_idx <= bit_idx + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tx_break)    state_nxt = BREAK;
                else if (!empty) state_nxt = START;
            end
            START:  if (bit_end) state_nxt = DATA;
            DATA:   if (bit_end && last_data) state_nxt = has_par_q ? PARITY : STOP;
            PARITY: if (bit_end) state_nxt = STOP;
            STOP: begin
                if (stop_end) begin
                    if (tx_break)    state_nxt = BREAK;
                    else if (!empty) state_nxt = START;
                    else             state_nxt = IDLE;
                end
            end
            BREAK:  if (!tx_break) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic tx_nxt, busy_nxt, done_nxt;

    always_comb begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        done_nxt = stop_end;
        case (state)
            START:   begin tx_nxt = 1'b0;  busy_nxt = 1'b1; end
            DATA:    begin tx_nxt = sh[0]; busy_nxt = 1'b1; end
            PARITY:  begin tx_nxt = par_q; busy_nxt = 1'b1; end
            STOP:    begin tx_nxt = 1'b1;  busy_nxt = 1'b1; end
            BREAK:   tx_nxt = 1'b0;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx         <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tx         <= tx_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: framing, parity modes, break, back-to-back frames,
// config latching and mid-frame reset, each frame compared bit by bit against literal patterns.
module tb_uart_tx_fifo;

    logic        clock;
    logic        reset;
    logic [8:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] cfg_div;
    logic [3:0]  cfg_data_bits;
    logic [2:0]  cfg_parity;
    logic        cfg_stop2;
    logic        tx_break;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [2:0]  fifo_level;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(
        .MAX_DATA_BITS(9),
        .DIV_WIDTH(16),
        .FIFO_DEPTH(4),
        .LVL_WIDTH(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .cfg_div(cfg_div),
        .cfg_data_bits(cfg_data_bits),
        .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2),
        .tx_break(tx_break),
        .tx(tx),
        .busy(busy),
        .frame_done(frame_done),
        .fifo_level(fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [8:0] w);
        din       = w;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, output int lat);
        lat = 0;
        while (tx !== 1'b0 && lat < 16) begin
            step();
            lat++;
        end
        chk({tag, "_start"}, {31'b0, tx}, 32'd0);
    endtask

    // Current sample must be the first clock of the frame; ends on its last clock.
    task automatic run_frame(input string tag, input logic [15:0] vec, input int nb, input int blen);
        int          done_at;
        logic [31:0] s;
        logic [31:0] ex;
        done_at = -1;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        for (int b = 0; b < nb; b++) begin
            s = '0;
            for (int j = 0; j < blen; j++) begin
                if (b > 0 || j > 0) step();
                s[j] = tx;
                if (frame_done === 1'b1 && done_at < 0) done_at = b * blen + j;
            end
            ex = vec[b] ? ((32'd1 << blen) - 32'd1) : 32'd0;
            chk($sformatf("%s_bit%0d", tag, b), s, ex);
        end
        chk({tag, "_done"}, done_at, nb * blen - 1);
    endtask

    logic [8:0] words [5];
    int lat;
    int n_done;
    int n_low;

    initial begin
        words = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
        reset = 1'b1;
        din = '0;
        din_valid = 1'b0;
        cfg_div = 16'd3;
        cfg_data_bits = 4'd8;
        cfg_parity = 3'b000;
        cfg_stop2 = 1'b0;
        tx_break = 1'b0;
        step();
        step();
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, frame_done}, 32'd0);
        chk("rst_lvl", {29'b0, fifo_level}, 32'd0);
        chk("rst_rdy", {31'b0, din_ready}, 32'd1);
        reset = 1'b0;
        step();

        // 8N1, 4 clocks per bit, 0x55
        push_word(9'h055);
        wait_start("t1", lat);
        chk("t1_latency", lat, 32'd2);
        run_frame("t1", 16'h02AA, 10, 4);
        step();
        chk("t1_idle_tx", {31'b0, tx}, 32'd1);
        chk("t1_idle_busy", {31'b0, busy}, 32'd0);

        // 7E2 at 1 clock per bit, then 7O2
        cfg_div = 16'd0;
        cfg_data_bits = 4'd7;
        cfg_parity = 3'b001;
        cfg_stop2 = 1'b1;
        push_word(9'h041);
        wait_start("t2e", lat);
        run_frame("t2e", 16'h0682, 11, 1);
        step();
        cfg_parity = 3'b010;
        push_word(9'h041);
        wait_start("t2o", lat);
        run_frame("t2o", 16'h0782, 11, 1);
        step();

        // Break while idle, fill the FIFO, then release
        cfg_div = 16'd1;
        cfg_data_bits = 4'd8;
        cfg_parity = 3'b000;
        cfg_stop2 = 1'b0;
        tx_break = 1'b1;
        step();
        step();
        chk("brk_tx", {31'b0, tx}, 32'd0);
        for (int w = 0; w < 5; w++) begin
            din = words[w];
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        chk("brk_lvl", {29'b0, fifo_level}, 32'd4);
        chk("brk_rdy", {31'b0, din_ready}, 32'd0);
        chk("brk_tx_hold", {31'b0, tx}, 32'd0);
        tx_break = 1'b0;
        step();
        chk("rel_tx0", {31'b0, tx}, 32'd0);
        step();
        chk("rel_tx1", {31'b0, tx}, 32'd1);
        chk("rel_lvl", {29'b0, fifo_level}, 32'd3);
        step();
        run_frame("b0", 16'h0222, 10, 2);
        chk("b0_lvl", {29'b0, fifo_level}, 32'd2);
        step();
        run_frame("b1", 16'h0244, 10, 2);
        chk("b1_lvl", {29'b0, fifo_level}, 32'd1);
        step();
        run_frame("b2", 16'h0266, 10, 2);
        chk("b2_lvl", {29'b0, fifo_level}, 32'd0);
        step();
        run_frame("b3", 16'h0288, 10, 2);
        step();
        chk("b_end_tx", {31'b0, tx}, 32'd1);
        chk("b_end_busy", {31'b0, busy}, 32'd0);
        chk("b_end_lvl", {29'b0, fifo_level}, 32'd0);

        // Data-bit clamp to 9 with mark parity
        cfg_div = 16'd0;
        cfg_data_bits = 4'd12;
        cfg_parity = 3'b011;
        push_word(9'h1A5);
        wait_start("t4", lat);
        run_frame("t4", 16'h0F4A, 12, 1);
        step();

        // Config changes mid-frame only affect the following frame
        cfg_div = 16'd3;
        cfg_data_bits = 4'd8;
        cfg_parity = 3'b001;
        push_word(9'h003);
        push_word(9'h003);
        chk("t5_lvl", {29'b0, fifo_level}, 32'd1);
        wait_start("t5", lat);
        cfg_div = 16'd7;
        cfg_parity = 3'b010;
        run_frame("t5a", 16'h0406, 11, 4);
        chk("t5a_lvl", {29'b0, fifo_level}, 32'd0);
        step();
        run_frame("t5b", 16'h0606, 11, 8);
        step();

        // Reset in the middle of DATA with two words queued
        cfg_div = 16'd3;
        cfg_parity = 3'b000;
        push_word(9'h0F0);
        push_word(9'h00F);
        push_word(9'h0AA);
        wait_start("t6", lat);
        for (int i = 0; i < 8; i++) step();
        chk("t6_busy_pre", {31'b0, busy}, 32'd1);
        chk("t6_lvl_pre", {29'b0, fifo_level}, 32'd2);
        reset = 1'b1;
        step();
        chk("t6_tx", {31'b0, tx}, 32'd1);
        chk("t6_busy", {31'b0, busy}, 32'd0);
        chk("t6_lvl", {29'b0, fifo_level}, 32'd0);
        chk("t6_rdy", {31'b0, din_ready}, 32'd1);
        chk("t6_done", {31'b0, frame_done}, 32'd0);
        reset = 1'b0;
        n_done = 0;
        n_low = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (frame_done === 1'b1) n_done++;
            if (tx !== 1'b1) n_low++;
        end
        chk("t6_no_done", n_done, 32'd0);
        chk("t6_tx_idle", n_low, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
